// File: rtl/reg_wr_arbiter.sv
// Two-channel writeback arbiter: per-channel FIFOs feed a round-robin grant into a registered
// register-file write bus. Define ARB_FIXED_PRIO_EN to give ch1 (load) strict priority instead.

module reg_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         clk_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [PW:0]             count;
    logic                    do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: it is only read when count says the entry is live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module reg_wr_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              clk_rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              W_Src,
    output logic              idle
);
    localparam int EW = ADDR_W + DATA_W;

    logic [1:0]         push, pop, full, empty;
    logic [1:0][EW-1:0] din, head;
    logic               grant, grant_ch;
    logic [EW-1:0]      head_sel;

    assign din[0]     = {req0_addr, req0_data};
    assign din[1]     = {req1_addr, req1_data};
    assign push       = {req1_valid, req0_valid} & ~full;
    assign req0_ready = !full[0];
    assign req1_ready = !full[1];

    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_ch
            reg_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
                .clk     (clk),
                .clk_rst (clk_rst),
                .push    (push[ch]),
                .pop     (pop[ch]),
                .din     (din[ch]),
                .dout    (head[ch]),
                .full    (full[ch]),
                .empty   (empty[ch])
            );
        end
    endgenerate

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        grant    = 1'b0;
        grant_ch = 1'b0;
        if (!empty[1]) begin
            grant    = 1'b1;
            grant_ch = 1'b1;
        end else if (!empty[0]) begin
            grant    = 1'b1;
            grant_ch = 1'b0;
        end
    end
`else
    logic last_grant;

    always_comb begin
        grant    = 1'b0;
        grant_ch = 1'b0;
        if (!empty[0] && !empty[1]) begin
            grant    = 1'b1;
            grant_ch = !last_grant;
        end else if (!empty[0]) begin
            grant    = 1'b1;
            grant_ch = 1'b0;
        end else if (!empty[1]) begin
            grant    = 1'b1;
            grant_ch = 1'b1;
        end
    end

    // Reset to 1 so ch0 takes the first contended grant.
    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst)   last_grant <= 1'b1;
        else if (grant) last_grant <= grant_ch;
    end
`endif

    assign pop      = grant ? (2'b01 << grant_ch) : 2'b00;
    assign head_sel = head[grant_ch];

    // x0 entries still pop and update W_*, but never raise the write enable.
    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst) begin
            Reg_Write <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
            W_Src     <= 1'b0;
        end else if (grant) begin
            Reg_Write <= (head_sel[EW-1:DATA_W] != '0);
            W_Addr    <= head_sel[EW-1:DATA_W];
            W_Data    <= head_sel[DATA_W-1:0];
            W_Src     <= grant_ch;
        end else begin
            Reg_Write <= 1'b0;
        end
    end

    assign idle = (&empty) && !Reg_Write;
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
Shares the register-file write port between two writeback requesters: ch0 (ALU result) and ch1 (load data). Each channel has a small FIFO behind a valid/ready handshake. A round-robin arbiter drains one entry per cycle into a registered write bus that drives the register file's Reg_Write/W_Addr/W_Data inputs. Sits between the execute/memory stages and the register file.

Parameters:
FIFO_DEPTH, 2, entries per channel FIFO; power of 2, minimum 2
ADDR_W, 5, register address width
DATA_W, 32, write data width

Ports:
clk  in  1  system clock, all state on posedge
clk_rst  in  1  asynchronous active-low reset
req0_valid  in  1  ch0 write request valid
req0_addr  in  ADDR_W  ch0 destination register
req0_data  in  DATA_W  ch0 write data
req0_ready  out  1  ch0 FIFO can accept
req1_valid  in  1  ch1 write request valid
req1_addr  in  ADDR_W  ch1 destination register
req1_data  in  DATA_W  ch1 write data
req1_ready  out  1  ch1 FIFO can accept
Reg_Write  out  1  register-file write enable, registered
W_Addr  out  ADDR_W  register-file write address, registered
W_Data  out  DATA_W  register-file write data, registered
W_Src  out  1  channel that produced the current W_* (0/1), registered
idle  out  1  both FIFOs empty and Reg_Write low

Behaviour:
- Interface: one clock, clk; reset clk_rst, asynchronous, active-low.
- Reset (clk_rst=0, asynchronous):
  - FIFO pointers and counts are cleared; any contents are discarded.
  - Reg_Write=0, W_Addr=0, W_Data=0, W_Src=0, idle=1.
  - last_grant=1, so ch0 wins the first contention.
  - Reset mid-operation drops all pending writes; no partial write is issued.
- Handshake:
  - A request is accepted on a posedge where valid and ready are both high.
  - readyN = !fullN, combinational from the count only. No same-cycle pass-through: a full FIFO stays not-ready even when it is popped that cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
- Arbitration (combinational, on the FIFO heads):
  - Neither FIFO non-empty: no grant.
  - One FIFO non-empty: grant it.
  - Both non-empty: grant the channel != last_grant.
  - last_grant updates only on a grant.
  - The granted FIFO pops on the same edge that loads the output register.
- Output register, each posedge:
  - W_Addr, W_Data and W_Src load from the granted head.
  - Reg_Write = grant && (head_addr != 0). Writes to x0 are consumed but never asserted.
  - No grant: Reg_Write=0; W_Addr, W_Data and W_Src hold their values.
  - Reg_Write is a single-cycle pulse per entry.
- Latency:
  - A request accepted at edge k into an empty FIFO with no contention has Reg_Write high from edge k+1 to edge k+2.
  - Contention adds one cycle per competing grant.
- Throughput: 1 write per cycle total. Under continuous contention, grants alternate ch0/ch1.
- Ordering: FIFO order within a channel. Across channels, order follows grant order; the requesters own any same-address hazards.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: ch1 (load) has strict priority whenever its FIFO is non-empty; last_grant is unused. ch0 can starve.
- Undefined: round-robin as above.

Test Plan:
- Reset then idle: clk_rst low→high, no requests -> Reg_Write=0, W_Addr=0, W_Data=0, idle=1, both ready=1.
- Single write: req0 {addr=5, data=0x1234} accepted at edge k -> during cycle k+1..k+2: Reg_Write=1, W_Addr=5, W_Data=0x00001234, W_Src=0; Reg_Write=0 after.
- Contention: ch0 {3,0xA} and ch1 {4,0xB} accepted the same edge -> ch0 write first, ch1 write next cycle (round-robin). With ARB_FIXED_PRIO_EN: ch1 first.
- x0 drop: req1 {addr=0, data=0xFFFF} -> entry consumed (idle returns to 1), Reg_Write never asserted, W_Src=1.
- Full/backpressure: hold req1_valid with 3 distinct entries while ch0 floods, FIFO_DEPTH=2 -> req1_ready=0 after 2 accepted; all 3 ch1 entries are written in order, none lost.
- Async reset mid-burst: clk_rst low with both FIFOs holding 2 entries -> outputs 0 immediately; after release no stale writes appear.
